// File: rtl/dma_sequencer_if.sv
// Bundles the instruction request, status, data-memory and CGRA buffer buses of the DMA sequencer.
// Signal suffixes are relative to the sequencer: master = sequencer side, slave = core/memory side.
interface dma_sequencer_if #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int CGRA_AW = 6
);
  logic               req_valid_i;
  logic [1:0]         dma_ctrl_i;
  logic [AW-1:0]      base_i;
  logic [31:0]        len_i;
  logic               stall_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;
  logic [AW-1:0]      dmem_addr_o;
  logic               dmem_ren_o;
  logic               dmem_wen_o;
  logic [DW-1:0]      dmem_wdata_o;
  logic [DW-1:0]      dmem_rdata_i;
  logic [CGRA_AW-1:0] cgra_addr_o;
  logic               cgra_ren_o;
  logic               cgra_wen_o;
  logic [DW-1:0]      cgra_wdata_o;
  logic [DW-1:0]      cgra_rdata_i;
  logic               cgra_start_o;
  logic               cgra_done_i;

  modport master (
    input  req_valid_i, dma_ctrl_i, base_i, len_i, dmem_rdata_i, cgra_rdata_i, cgra_done_i,
    output stall_o, busy_o, done_o, err_o,
    output dmem_addr_o, dmem_ren_o, dmem_wen_o, dmem_wdata_o,
    output cgra_addr_o, cgra_ren_o, cgra_wen_o, cgra_wdata_o, cgra_start_o
  );

  modport slave (
    output req_valid_i, dma_ctrl_i, base_i, len_i, dmem_rdata_i, cgra_rdata_i, cgra_done_i,
    input  stall_o, busy_o, done_o, err_o,
    input  dmem_addr_o, dmem_ren_o, dmem_wen_o, dmem_wdata_o,
    input  cgra_addr_o, cgra_ren_o, cgra_wen_o, cgra_wdata_o, cgra_start_o
  );
endinterface

// File: rtl/dma_sequencer.sv
// Executes STC/LFC block copies between data memory and the CGRA buffer and the SCA start/wait
// handshake, stalling the core until the operation retires.
module dma_sequencer #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int CGRA_AW  = 6,
  parameter int WAIT_MAX = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dma_sequencer_if.master  bus
);
  localparam int DEPTH = 2 ** CGRA_AW;
  localparam int IW    = CGRA_AW + 1;
  localparam int TW    = $clog2(WAIT_MAX + 1);

  localparam logic [1:0] OP_STC = 2'b01;
  localparam logic [1:0] OP_LFC = 2'b10;
  localparam logic [1:0] OP_SCA = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_START, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic [AW-1:0] base_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] timer_q;
  logic          err_q;

  logic          accept;
  logic [IW-1:0] len_d;
  logic [IW-1:0] idx_d;
  logic [AW-1:0] dmem_byte_addr;
  logic [DW-1:0] wr_data;

  assign accept = bus.req_valid_i && (bus.dma_ctrl_i != 2'b00);
  // Clamp to the buffer depth; idx has one extra bit so a full-depth count still terminates.
  assign len_d  = (bus.len_i > 32'(DEPTH)) ? IW'(DEPTH) : IW'(bus.len_i);
  assign idx_d  = idx_q + IW'(1);
  assign dmem_byte_addr = base_q + (AW'(idx_q) << 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= bus.dma_ctrl_i;
            base_q <= bus.base_i;
            len_q  <= len_d;
            idx_q  <= '0;
            err_q  <= 1'b0;
            if (bus.dma_ctrl_i == OP_SCA)  state_q <= S_START;
            else if (len_d == '0)          state_q <= S_DONE;
            else                           state_q <= S_RD;
          end
        end
        S_RD: state_q <= S_WR;
        S_WR: begin
          idx_q   <= idx_d;
          state_q <= (idx_d < len_q) ? S_RD : S_DONE;
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle takes priority over the timeout.
          if (bus.cgra_done_i) begin
            state_q <= S_DONE;
          end else if (timer_q == TW'(WAIT_MAX - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_data = (op_q == OP_STC) ? bus.dmem_rdata_i : bus.cgra_rdata_i;

  // Strobes decode from the registered state only; the accept-cycle stall is the sole input path.
  always_comb begin
    bus.stall_o      = 1'b0;
    bus.busy_o       = (state_q != S_IDLE);
    bus.done_o       = (state_q == S_DONE);
    bus.err_o        = err_q;
    bus.dmem_addr_o  = '0;
    bus.dmem_ren_o   = 1'b0;
    bus.dmem_wen_o   = 1'b0;
    bus.dmem_wdata_o = '0;
    bus.cgra_addr_o  = '0;
    bus.cgra_ren_o   = 1'b0;
    bus.cgra_wen_o   = 1'b0;
    bus.cgra_wdata_o = '0;
    bus.cgra_start_o = 1'b0;
    case (state_q)
      S_IDLE: bus.stall_o = accept && !rst_i;
      S_RD: begin
        bus.stall_o = 1'b1;
        if (op_q == OP_STC) begin
          bus.dmem_ren_o  = 1'b1;
          bus.dmem_addr_o = dmem_byte_addr;
        end else if (op_q == OP_LFC) begin
          bus.cgra_ren_o  = 1'b1;
          bus.cgra_addr_o = idx_q[CGRA_AW-1:0];
        end
      end
      S_WR: begin
        bus.stall_o = 1'b1;
        if (op_q == OP_STC) begin
          bus.cgra_wen_o   = 1'b1;
          bus.cgra_addr_o  = idx_q[CGRA_AW-1:0];
          bus.cgra_wdata_o = wr_data;
        end else if (op_q == OP_LFC) begin
          bus.dmem_wen_o   = 1'b1;
          bus.dmem_addr_o  = dmem_byte_addr;
          bus.dmem_wdata_o = wr_data;
        end
      end
      S_START: begin
        bus.stall_o      = 1'b1;
        bus.cgra_start_o = 1'b1;
      end
      S_WAIT:  bus.stall_o = 1'b1;
      default: bus.stall_o = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer: memory/CGRA models with registered reads and a programmable
// CGRA done responder; each scenario task checks its own hand-computed expectations.
`timescale 1ns/1ps
module tb_dma_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_sequencer_if #(.DW(32), .AW(32), .CGRA_AW(6)) bus ();

  dma_sequencer #(.DW(32), .AW(32), .CGRA_AW(6), .WAIT_MAX(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  logic [31:0] dmem [0:1023];
  logic [31:0] cgra_mem [0:63];
  logic [31:0] rd_log [$];
  int cgra_wen_cnt = 0, dmem_wen_cnt = 0, cgra_ren_cnt = 0, start_cnt = 0, overlap_cnt = 0;
  int sca_delay = 0;
  int cd = 0;
  int total = 0, bad = 0;

  assign bus.cgra_done_i = (cd == 1);

  always @(posedge clk) begin
    if (bus.dmem_ren_o) begin
      bus.dmem_rdata_i <= dmem[bus.dmem_addr_o[11:2]];
      rd_log.push_back(bus.dmem_addr_o);
    end
    if (bus.dmem_wen_o) begin
      dmem[bus.dmem_addr_o[11:2]] <= bus.dmem_wdata_o;
      dmem_wen_cnt <= dmem_wen_cnt + 1;
    end
    if (bus.cgra_ren_o) begin
      bus.cgra_rdata_i <= cgra_mem[bus.cgra_addr_o];
      cgra_ren_cnt <= cgra_ren_cnt + 1;
    end
    if (bus.cgra_wen_o) begin
      cgra_mem[bus.cgra_addr_o] <= bus.cgra_wdata_o;
      cgra_wen_cnt <= cgra_wen_cnt + 1;
    end
    if (bus.cgra_start_o) start_cnt <= start_cnt + 1;
    if ((bus.dmem_ren_o || bus.dmem_wen_o) && (bus.cgra_ren_o || bus.cgra_wen_o || bus.cgra_start_o))
      overlap_cnt <= overlap_cnt + 1;
    if (bus.cgra_start_o && sca_delay > 0) cd <= sca_delay;
    else if (cd > 0) cd <= cd - 1;
  end

  // Drives one request in cycle 1, then counts stall cycles until done_o (cycle-bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] base, input logic [31:0] len,
                        output int stalls, output int done_cyc);
    int cyc;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.dma_ctrl_i = op; bus.base_i = base; bus.len_i = len;
    #1;
    stalls = bus.stall_o ? 1 : 0;
    done_cyc = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.dma_ctrl_i = 2'b00;
    cyc = 2;
    while (done_cyc == 0 && cyc < 3000) begin
      if (bus.done_o) done_cyc = cyc;
      else begin
        if (bus.stall_o) stalls++;
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    repeat (3) @(negedge clk);
    flags = {bus.stall_o, bus.busy_o, bus.done_o, bus.err_o, bus.dmem_ren_o, bus.dmem_wen_o,
             bus.cgra_ren_o, bus.cgra_wen_o, bus.cgra_start_o};
    total++; if (flags !== 9'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", flags); end
    total++; if (bus.dmem_addr_o !== 32'h0 || bus.cgra_addr_o !== 6'h0 || bus.dmem_wdata_o !== 32'h0 || bus.cgra_wdata_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr_data got=%h/%h/%h/%h exp=0", bus.dmem_addr_o, bus.cgra_addr_o, bus.dmem_wdata_o, bus.cgra_wdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_stc();
    int stalls, done_cyc, n0, w0;
    n0 = rd_log.size(); w0 = cgra_wen_cnt;
    run_op(2'b01, 32'h100, 32'd4, stalls, done_cyc);
    $display("stc base=0x100 len=4 stalls=%0d done_cycle=%0d", stalls, done_cyc);
    total++; if (stalls !== 9) begin bad++; $display("FAIL stc_stalls got=%0d exp=9", stalls); end
    total++; if (done_cyc !== 10) begin bad++; $display("FAIL stc_done_cycle got=%0d exp=10", done_cyc); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cgra_mem[i] !== (32'hA0A0_0000 + 32'(i))) begin bad++; $display("FAIL stc_cgra[%0d] got=%h exp=%h", i, cgra_mem[i], 32'hA0A0_0000 + 32'(i)); end
    end
    total++; if (rd_log.size() - n0 !== 4) begin bad++; $display("FAIL stc_reads got=%0d exp=4", rd_log.size() - n0); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (rd_log[n0+i] !== 32'h100 + 32'(4*i)) begin bad++; $display("FAIL stc_rd_addr[%0d] got=%h exp=%h", i, rd_log[n0+i], 32'h100 + 32'(4*i)); end
    end
    total++; if (cgra_wen_cnt - w0 !== 4) begin bad++; $display("FAIL stc_cgra_writes got=%0d exp=4", cgra_wen_cnt - w0); end
  endtask

  task automatic test_lfc();
    int stalls, done_cyc, cw0, dw0;
    for (int i = 0; i < 3; i++) cgra_mem[i] <= 32'hB0B0_0000 + 32'(i);
    cw0 = cgra_wen_cnt; dw0 = dmem_wen_cnt;
    run_op(2'b10, 32'h200, 32'd3, stalls, done_cyc);
    $display("lfc base=0x200 len=3 stalls=%0d done_cycle=%0d", stalls, done_cyc);
    total++; if (stalls !== 7 || done_cyc !== 8) begin bad++; $display("FAIL lfc_timing got=%0d/%0d exp=7/8", stalls, done_cyc); end
    for (int i = 0; i < 3; i++) begin
      total++; if (dmem[128+i] !== (32'hB0B0_0000 + 32'(i))) begin bad++; $display("FAIL lfc_dmem[%0d] got=%h exp=%h", i, dmem[128+i], 32'hB0B0_0000 + 32'(i)); end
    end
    total++; if (cgra_wen_cnt !== cw0 || dmem_wen_cnt - dw0 !== 3) begin bad++; $display("FAIL lfc_strobes cgra_wen=%0d dmem_wen=%0d exp=0/3", cgra_wen_cnt - cw0, dmem_wen_cnt - dw0); end
  endtask

  task automatic test_len_bounds();
    int stalls, done_cyc, n0, cw0, dw0, cr0;
    n0 = rd_log.size(); cw0 = cgra_wen_cnt; dw0 = dmem_wen_cnt; cr0 = cgra_ren_cnt;
    run_op(2'b01, 32'h300, 32'd0, stalls, done_cyc);
    $display("stc len=0 stalls=%0d done_cycle=%0d", stalls, done_cyc);
    total++; if (stalls !== 1 || done_cyc !== 2) begin bad++; $display("FAIL len0_timing got=%0d/%0d exp=1/2", stalls, done_cyc); end
    total++; if (rd_log.size() != n0 || cgra_wen_cnt != cw0 || dmem_wen_cnt != dw0 || cgra_ren_cnt != cr0) begin
      bad++; $display("FAIL len0_strobes some strobe fired, exp none");
    end
    for (int i = 0; i < 64; i++) dmem[256+i] <= 32'hC000_0000 + 32'(i);
    cw0 = cgra_wen_cnt;
    run_op(2'b01, 32'h400, 32'd100, stalls, done_cyc);
    $display("stc len=100 stalls=%0d done_cycle=%0d", stalls, done_cyc);
    total++; if (stalls !== 129 || done_cyc !== 130) begin bad++; $display("FAIL clamp_timing got=%0d/%0d exp=129/130", stalls, done_cyc); end
    total++; if (cgra_wen_cnt - cw0 !== 64) begin bad++; $display("FAIL clamp_words got=%0d exp=64", cgra_wen_cnt - cw0); end
    total++; if (cgra_mem[63] !== 32'hC000_003F || cgra_mem[0] !== 32'hC000_0000) begin
      bad++; $display("FAIL clamp_data got=%h/%h exp=c0000000/c000003f", cgra_mem[0], cgra_mem[63]);
    end
  endtask

  task automatic test_sca();
    int stalls, done_cyc, s0;
    sca_delay = 5; s0 = start_cnt;
    run_op(2'b11, 32'h0, 32'd99, stalls, done_cyc);
    $display("sca done_after=5 stalls=%0d done_cycle=%0d err=%b", stalls, done_cyc, bus.err_o);
    total++; if (stalls !== 7 || done_cyc !== 8) begin bad++; $display("FAIL sca_timing got=%0d/%0d exp=7/8", stalls, done_cyc); end
    total++; if (start_cnt - s0 !== 1 || bus.err_o !== 1'b0) begin bad++; $display("FAIL sca_start_err starts=%0d err=%b exp=1/0", start_cnt - s0, bus.err_o); end
    sca_delay = 0;
    run_op(2'b11, 32'h0, 32'd0, stalls, done_cyc);
    $display("sca no_done stalls=%0d done_cycle=%0d err=%b", stalls, done_cyc, bus.err_o);
    total++; if (stalls !== 10 || done_cyc !== 11) begin bad++; $display("FAIL sca_timeout_timing got=%0d/%0d exp=10/11", stalls, done_cyc); end
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL sca_timeout_err got=%b exp=1", bus.err_o); end
    @(negedge clk);
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL sca_err_sticky got=%b exp=1", bus.err_o); end
    sca_delay = 8;
    run_op(2'b11, 32'h0, 32'd0, stalls, done_cyc);
    $display("sca done_on_expiry stalls=%0d done_cycle=%0d err=%b", stalls, done_cyc, bus.err_o);
    total++; if (stalls !== 10 || done_cyc !== 11 || bus.err_o !== 1'b0) begin
      bad++; $display("FAIL sca_expiry_tie got=%0d/%0d err=%b exp=10/11 err=0", stalls, done_cyc, bus.err_o);
    end
    sca_delay = 0;
  endtask

  task automatic test_reset_abort();
    int stalls, done_cyc;
    logic [8:0] flags;
    for (int i = 0; i < 4; i++) begin
      cgra_mem[i] <= 32'hDEAD_0000 + 32'(i);
      dmem[16+i]  <= 32'h5000_0000 + 32'(i);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.dma_ctrl_i = 2'b01; bus.base_i = 32'h40; bus.len_i = 32'd4;
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.dma_ctrl_i = 2'b00;
    repeat (5) @(negedge clk);
    total++; if (bus.cgra_wen_o !== 1'b1 || bus.cgra_addr_o !== 6'd2) begin bad++; $display("FAIL abort_in_wr2 wen=%b addr=%0d exp=1/2", bus.cgra_wen_o, bus.cgra_addr_o); end
    rst = 1'b1;
    #1;
    flags = {bus.stall_o, bus.busy_o, bus.done_o, bus.err_o, bus.dmem_ren_o, bus.dmem_wen_o,
             bus.cgra_ren_o, bus.cgra_wen_o, bus.cgra_start_o};
    $display("abort rst during WR idx=2 flags=%b", flags);
    total++; if (flags !== 9'b0 || bus.cgra_addr_o !== 6'd0 || bus.cgra_wdata_o !== 32'h0 || bus.dmem_addr_o !== 32'h0) begin
      bad++; $display("FAIL abort_outputs flags=%b caddr=%0d cwdata=%h daddr=%h exp=0", flags, bus.cgra_addr_o, bus.cgra_wdata_o, bus.dmem_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    total++; if (cgra_mem[0] !== 32'h5000_0000 || cgra_mem[1] !== 32'h5000_0001) begin bad++; $display("FAIL abort_head got=%h/%h exp=50000000/50000001", cgra_mem[0], cgra_mem[1]); end
    total++; if (cgra_mem[2] !== 32'hDEAD_0002 || cgra_mem[3] !== 32'hDEAD_0003) begin bad++; $display("FAIL abort_tail got=%h/%h exp=dead0002/dead0003", cgra_mem[2], cgra_mem[3]); end
    run_op(2'b01, 32'h40, 32'd4, stalls, done_cyc);
    $display("stc after abort stalls=%0d done_cycle=%0d", stalls, done_cyc);
    total++; if (stalls !== 9 || cgra_mem[3] !== 32'h5000_0003) begin bad++; $display("FAIL abort_rerun stalls=%0d cgra3=%h exp=9/50000003", stalls, cgra_mem[3]); end
  endtask

  task automatic test_wrap();
    int stalls, done_cyc, n0;
    dmem[1023] <= 32'h7777_0001;
    dmem[0]    <= 32'h7777_0002;
    n0 = rd_log.size();
    run_op(2'b01, 32'hFFFF_FFFC, 32'd2, stalls, done_cyc);
    $display("stc wrap base=0xfffffffc len=2 stalls=%0d", stalls);
    total++; if (rd_log.size() - n0 !== 2) begin bad++; $display("FAIL wrap_reads got=%0d exp=2", rd_log.size() - n0); end
    else begin
      total++; if (rd_log[n0] !== 32'hFFFF_FFFC || rd_log[n0+1] !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h/%h exp=fffffffc/00000000", rd_log[n0], rd_log[n0+1]); end
    end
    total++; if (cgra_mem[0] !== 32'h7777_0001 || cgra_mem[1] !== 32'h7777_0002) begin bad++; $display("FAIL wrap_data got=%h/%h exp=77770001/77770002", cgra_mem[0], cgra_mem[1]); end
  endtask

  task automatic test_ignore();
    int cyc;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.dma_ctrl_i = 2'b00; bus.base_i = 32'h0; bus.len_i = 32'd4;
    #1;
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL nop_stall got=%b exp=0", bus.stall_o); end
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL nop_busy got=%b exp=0", bus.busy_o); end
    bus.dma_ctrl_i = 2'b01; bus.base_i = 32'h100; bus.len_i = 32'd1;
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.dma_ctrl_i = 2'b00;
    cyc = 0;
    while (!bus.done_o && cyc < 20) begin @(negedge clk); cyc++; end
    total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL ign_first_done got=%b exp=1", bus.done_o); end
    bus.req_valid_i = 1'b1; bus.dma_ctrl_i = 2'b10; bus.base_i = 32'h300; bus.len_i = 32'd1;
    #1;
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL ign_done_stall got=%b exp=0", bus.stall_o); end
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b1) begin bad++; $display("FAIL ign_idle_accept busy=%b stall=%b exp=0/1", bus.busy_o, bus.stall_o); end
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.dma_ctrl_i = 2'b00;
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL ign_second_busy got=%b exp=1", bus.busy_o); end
    cyc = 0;
    while (!bus.done_o && cyc < 20) begin @(negedge clk); cyc++; end
    $display("lfc after done-cycle request dmem[0x300]=%h", dmem[192]);
    total++; if (dmem[192] !== 32'hA0A0_0000) begin bad++; $display("FAIL ign_second_data got=%h exp=a0a00000", dmem[192]); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.dma_ctrl_i = 2'b00; bus.base_i = '0; bus.len_i = '0;
    for (int i = 0; i < 4; i++) dmem[64+i] <= 32'hA0A0_0000 + 32'(i);
    test_reset();
    test_stc();
    test_lfc();
    test_len_bounds();
    test_sca();
    test_reset_abort();
    test_wrap();
    test_ignore();
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
